if_id_buffer: RTL and testbench

- Fetch-to-decode boundary of the 5-stage 16-bit pipeline.
- Captures each fetched {nxtPc, instr} pair into a 2-entry elastic buffer and presents the head as the IF/ID pipeline register (nxtPcIfId, instrIfId, validInsIfId).
- Absorbs decode stalls without a combinational path back to fetch; discards wrong-path instructions on flush; stops accepting after a HALT.

---
 rtl/if_id_buffer_pkg.sv | 28 ++
 rtl/if_id_entry_reg.sv | 48 ++++
 rtl/if_id_buffer.sv | 165 ++++++++++++++++
 tb/tb_if_id_buffer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared pipeline definitions: data width, NOP/HALT encodings, pipeline entry type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package if_id_buffer_pkg;

    localparam int DATA_W = 16;

    // Encoding driven downstream whenever no valid instruction is held.
    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

    // Opcode field value (instr[15:11]) that marks HALT.
    localparam logic [4:0] HALT_OPC = 5'b00000;

    // One pipeline register entry, shared with the later pipeline registers.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    // Value an entry register takes in reset: PC zero, NOP instruction.
    localparam entry_t ENTRY_RST = '{pc: 16'h0000, instr: NOP_INSTR};

    // True when the instruction word carries the HALT opcode.
    function automatic logic is_halt(input logic [DATA_W-1:0] instr);
        return instr[15:11] == HALT_OPC;
    endfunction

endpackage

// File: rtl/if_id_entry_reg.sv
// Loadable pipeline entry register with valid bit; clear drops only the valid bit.
// Latency: 1 cycle from ld to output.
// Backpressure: none; the owner decides when to load or clear.
module if_id_entry_reg
    import if_id_buffer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   ld,
    input  entry_t ld_dat,
    output entry_t dat,
    output logic   vld
);

    entry_t dat_d;
    entry_t dat_q;
    logic   vld_d;
    logic   vld_q;

    // Next state: clear wins over load; the payload is kept on clear so the
    // last PC stays visible after the entry is dropped.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (ld) begin
            vld_d = 1'b1;
            dat_d = ld_dat;
        end
    end

    // Entry state with asynchronous clear to empty/NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= ENTRY_RST;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign dat = dat_q;
    assign vld = vld_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register as a 2-entry elastic buffer (head + skid); optional stats via IFID_STATS_EN.
// Latency: 1 cycle from accept to outputs when empty or draining a single entry; else via skid.
// Backpressure: fetchReady is registered (no stall->ready comb path); low when full or after HALT.
module if_id_buffer
    import if_id_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetchValid,
    input  logic [DATA_W-1:0] fetchPc,
    input  logic [DATA_W-1:0] fetchInstr,
    output logic              fetchReady,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] nxtPcIfId,
    output logic [DATA_W-1:0] instrIfId,
    output logic              validInsIfId,
    output logic              haltSeen
`ifdef IFID_STATS_EN
    ,
    output logic [15:0]       stallCycles,
    output logic [15:0]       flushedIns
`endif
);

    entry_t     head_dat;
    entry_t     skid_dat;
    entry_t     head_din;
    entry_t     fetch_ent;
    logic       head_vld;
    logic       skid_vld;
    logic       head_ld;
    logic       head_clr;
    logic       skid_ld;
    logic       skid_clr;
    logic       accept;
    logic       consume;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       fetch_ready_d;
    logic       fetch_ready_q;
    logic       halt_seen_d;
    logic       halt_seen_q;

    assign fetch_ent = '{pc: fetchPc, instr: fetchInstr};
    // fetch_ready_q is already low whenever the buffer is full, so accept
    // never needs to look at stall.
    assign accept    = fetchValid && fetch_ready_q;
    assign consume   = head_vld && !stall;
    assign count_q   = {1'b0, head_vld} + {1'b0, skid_vld};

    if_id_entry_reg u_head (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (head_clr),
        .ld     (head_ld),
        .ld_dat (head_din),
        .dat    (head_dat),
        .vld    (head_vld)
    );

    if_id_entry_reg u_skid (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (skid_clr),
        .ld     (skid_ld),
        .ld_dat (fetch_ent),
        .dat    (skid_dat),
        .vld    (skid_vld)
    );

    // Steering of head/skid loads: flush empties both; a consume promotes the
    // skid entry (or the new fetch) into the head; otherwise new fetches fill
    // the first free slot, keeping strict FIFO order.
    always_comb begin
        head_ld  = 1'b0;
        head_clr = 1'b0;
        head_din = fetch_ent;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!head_vld) begin
            head_ld = accept;
        end else if (consume) begin
            if (skid_vld) begin
                head_ld  = 1'b1;
                head_din = skid_dat;
                skid_ld  = accept;
                skid_clr = !accept;
            end else if (accept) begin
                head_ld = 1'b1;
            end else begin
                head_clr = 1'b1;
            end
        end else if (accept && !skid_vld) begin
            skid_ld = 1'b1;
        end
    end

    // Next occupancy, HALT tracking and registered ready.
    always_comb begin
        count_d       = 2'd0;
        halt_seen_d   = 1'b0;
        if (!flush) begin
            count_d     = count_q + {1'b0, accept} - {1'b0, consume};
            halt_seen_d = halt_seen_q || (accept && is_halt(fetchInstr));
        end
        fetch_ready_d = (count_d < 2'd2) && !halt_seen_d;
    end

    // Control flops; ready comes up on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_ready_q <= 1'b0;
            halt_seen_q   <= 1'b0;
        end else begin
            fetch_ready_q <= fetch_ready_d;
            halt_seen_q   <= halt_seen_d;
        end
    end

    assign fetchReady   = fetch_ready_q;
    assign haltSeen     = halt_seen_q;
    assign validInsIfId = head_vld;
    assign nxtPcIfId    = head_dat.pc;
    assign instrIfId    = head_vld ? head_dat.instr : NOP_INSTR;

`ifdef IFID_STATS_EN
    logic [15:0] stall_cycles_d;
    logic [15:0] stall_cycles_q;
    logic [15:0] flushed_ins_d;
    logic [15:0] flushed_ins_q;
    logic [16:0] flush_sum;

    // Saturating counters: stalled-with-valid-head cycles and squashed instructions.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flushed_ins_d  = flushed_ins_q;
        flush_sum      = {1'b0, flushed_ins_q} + {15'b0, count_q} + {16'b0, fetchValid};
        if (stall && head_vld && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (flush) begin
            flushed_ins_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    // Statistics flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 16'h0000;
            flushed_ins_q  <= 16'h0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flushed_ins_q  <= flushed_ins_d;
        end
    end

    assign stallCycles = stall_cycles_q;
    assign flushedIns  = flushed_ins_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: vector table plus hand sequences for reset and stats.
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetchValid;
    logic [DATA_W-1:0] fetchPc;
    logic [DATA_W-1:0] fetchInstr;
    logic              fetchReady;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] nxtPcIfId;
    logic [DATA_W-1:0] instrIfId;
    logic              validInsIfId;
    logic              haltSeen;
`ifdef IFID_STATS_EN
    logic [15:0]       stallCycles;
    logic [15:0]       flushedIns;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .fetchValid   (fetchValid),
        .fetchPc      (fetchPc),
        .fetchInstr   (fetchInstr),
        .fetchReady   (fetchReady),
        .stall        (stall),
        .flush        (flush),
        .nxtPcIfId    (nxtPcIfId),
        .instrIfId    (instrIfId),
        .validInsIfId (validInsIfId),
        .haltSeen     (haltSeen)
`ifdef IFID_STATS_EN
        ,
        .stallCycles  (stallCycles),
        .flushedIns   (flushedIns)
`endif
    );

    typedef struct {
        logic        fv;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        stl;
        logic        fl;
        logic        e_rdy;
        logic        e_vld;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fv, logic [15:0] pc, logic [15:0] instr, logic stl, logic fl,
                                logic e_rdy, logic e_vld, logic [15:0] e_pc, logic [15:0] e_instr,
                                logic e_halt);
        vec_t v;
        v.fv = fv; v.pc = pc; v.instr = instr; v.stl = stl; v.fl = fl;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pc = e_pc; v.e_instr = e_instr; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic vld,
                            input logic [15:0] pc, input logic [15:0] instr, input logic halt);
        chk({tag, ".rdy"},   {15'b0, fetchReady},   {15'b0, rdy});
        chk({tag, ".vld"},   {15'b0, validInsIfId}, {15'b0, vld});
        chk({tag, ".pc"},    nxtPcIfId,             pc);
        chk({tag, ".instr"}, instrIfId,             instr);
        chk({tag, ".halt"},  {15'b0, haltSeen},     {15'b0, halt});
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic fv, input logic [15:0] pc, input logic [15:0] instr,
                        input logic stl, input logic fl);
        @(negedge clk);
        fetchValid = fv; fetchPc = pc; fetchInstr = instr; stall = stl; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; fetchValid = 1'b0; fetchPc = '0; fetchInstr = '0; stall = 1'b0; flush = 1'b0;

        //                fv  pc       instr    stl fl   rdy vld pc       instr    halt
        // streaming
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0,   1, 0, 16'h0000, 16'h0800, 0));
        vecs.push_back(mk(1, 16'h0002, 16'h4001, 0, 0,   1, 1, 16'h0002, 16'h4001, 0));
        vecs.push_back(mk(1, 16'h0004, 16'h4002, 0, 0,   1, 1, 16'h0004, 16'h4002, 0));
        vecs.push_back(mk(1, 16'h0006, 16'h4003, 0, 0,   1, 1, 16'h0006, 16'h4003, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0,   1, 0, 16'h0006, 16'h0800, 0));
        // stall fill: 4 stall cycles, skid takes 0x4002, ready drops
        vecs.push_back(mk(1, 16'h0002, 16'h4001, 0, 0,   1, 1, 16'h0002, 16'h4001, 0));
        vecs.push_back(mk(1, 16'h0004, 16'h4002, 1, 0,   0, 1, 16'h0002, 16'h4001, 0));
        vecs.push_back(mk(1, 16'h0006, 16'h4003, 1, 0,   0, 1, 16'h0002, 16'h4001, 0));
        vecs.push_back(mk(1, 16'h0006, 16'h4003, 1, 0,   0, 1, 16'h0002, 16'h4001, 0));
        vecs.push_back(mk(1, 16'h0006, 16'h4003, 1, 0,   0, 1, 16'h0002, 16'h4001, 0));
        vecs.push_back(mk(1, 16'h0006, 16'h4003, 0, 0,   1, 1, 16'h0004, 16'h4002, 0));
        vecs.push_back(mk(1, 16'h0006, 16'h4003, 0, 0,   1, 1, 16'h0006, 16'h4003, 0));
        // fill to two, then flush with stall and a presented fetch
        vecs.push_back(mk(1, 16'h0008, 16'h4004, 1, 0,   0, 1, 16'h0006, 16'h4003, 0));
        vecs.push_back(mk(1, 16'h0008, 16'h4005, 1, 1,   1, 0, 16'h0006, 16'h0800, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0,   1, 0, 16'h0006, 16'h0800, 0));
        // HALT accepted, drains, blocks later fetches, flush clears
        vecs.push_back(mk(1, 16'h000A, 16'h0000, 0, 0,   0, 1, 16'h000A, 16'h0000, 1));
        vecs.push_back(mk(1, 16'h000C, 16'h4006, 0, 0,   0, 0, 16'h000A, 16'h0800, 1));
        vecs.push_back(mk(1, 16'h000C, 16'h4006, 0, 0,   0, 0, 16'h000A, 16'h0800, 1));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1,   1, 0, 16'h000A, 16'h0800, 0));
        vecs.push_back(mk(1, 16'h000C, 16'h4006, 0, 0,   1, 1, 16'h000C, 16'h4006, 0));
        // fill to two for the asynchronous reset check
        vecs.push_back(mk(1, 16'h000E, 16'h4007, 1, 0,   0, 1, 16'h000C, 16'h4006, 0));

        // reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk_outs("reset", 1'b0, 1'b0, 16'h0000, 16'h0800, 1'b0);
`ifdef IFID_STATS_EN
        chk("reset.stallCycles", stallCycles, 16'h0000);
        chk("reset.flushedIns",  flushedIns,  16'h0000);
`endif
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].stl, vecs[i].fl);
            chk_outs($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_pc,
                     vecs[i].e_instr, vecs[i].e_halt);
        end

        // asynchronous reset between edges with two entries held
        #2;
        rst = 1'b0;
        #1;
        chk_outs("arst", 1'b0, 1'b0, 16'h0000, 16'h0800, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 16'h0000, 16'h0000, 0, 0);
        chk_outs("arst_rel", 1'b1, 1'b0, 16'h0000, 16'h0800, 1'b0);

`ifdef IFID_STATS_EN
        chk("arst.stallCycles", stallCycles, 16'h0000);
        step(1, 16'h0002, 16'h4001, 0, 0);
        step(1, 16'h0004, 16'h4002, 1, 0);
        chk("stats.stall1", stallCycles, 16'h0001);
        step(1, 16'h0004, 16'h4002, 1, 0);
        step(1, 16'h0004, 16'h4002, 1, 0);
        step(1, 16'h0006, 16'h4005, 0, 1);
        chk("stats.stallCycles", stallCycles, 16'h0003);
        chk("stats.flushedIns",  flushedIns,  16'h0003);
        chk("stats.flush_vld",   {15'b0, validInsIfId}, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
